// File: rtl/sdram_arbiter_if.sv
// Client-side and controller-side signals of the SDRAM arbiter, bundled.
// The slave view belongs to the arbiter and the master view to whatever drives it.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] dl_addr;
    logic [DATA_WIDTH-1:0] dl_data;
    logic                  dl_req;
    logic                  dl_ack;

    logic [ADDR_WIDTH-1:0] rd0_addr;
    logic                  rd0_req;
    logic                  rd0_ack;
    logic                  rd0_valid;
    logic [DATA_WIDTH-1:0] rd0_q;

    logic [ADDR_WIDTH-1:0] rd1_addr;
    logic                  rd1_req;
    logic                  rd1_ack;
    logic                  rd1_valid;
    logic [DATA_WIDTH-1:0] rd1_q;

    logic [ADDR_WIDTH-1:0] rd2_addr;
    logic                  rd2_req;
    logic                  rd2_ack;
    logic                  rd2_valid;
    logic [DATA_WIDTH-1:0] rd2_q;

    logic [ADDR_WIDTH-1:0] sdram_addr;
    logic [DATA_WIDTH-1:0] sdram_data;
    logic                  sdram_we;
    logic                  sdram_req;
    logic                  sdram_ack;
    logic                  sdram_valid;
    logic [DATA_WIDTH-1:0] sdram_q;

    modport slave (
        input  dl_addr, dl_data, dl_req,
        output dl_ack,
        input  rd0_addr, rd0_req,
        output rd0_ack, rd0_valid, rd0_q,
        input  rd1_addr, rd1_req,
        output rd1_ack, rd1_valid, rd1_q,
        input  rd2_addr, rd2_req,
        output rd2_ack, rd2_valid, rd2_q,
        output sdram_addr, sdram_data, sdram_we, sdram_req,
        input  sdram_ack, sdram_valid, sdram_q
    );

    modport master (
        output dl_addr, dl_data, dl_req,
        input  dl_ack,
        output rd0_addr, rd0_req,
        input  rd0_ack, rd0_valid, rd0_q,
        output rd1_addr, rd1_req,
        input  rd1_ack, rd1_valid, rd1_q,
        output rd2_addr, rd2_req,
        input  rd2_ack, rd2_valid, rd2_q,
        input  sdram_addr, sdram_data, sdram_we, sdram_req,
        output sdram_ack, sdram_valid, sdram_q
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Single-outstanding SDRAM arbiter: one download write port with priority
// over three round-robin read ports.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    sdram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            rr_q, rr_d;
    logic                  gnt_dl_q, gnt_dl_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic [2:0]            valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rdq_q [3];
    logic [DATA_WIDTH-1:0] rdq_d [3];

    logic [2:0]            rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr [3];
    logic [1:0]            p0, p1, p2, pick;
    logic                  ack_en;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign rd_req     = {bus.rd2_req, bus.rd1_req, bus.rd0_req};
    assign rd_addr[0] = bus.rd0_addr;
    assign rd_addr[1] = bus.rd1_addr;
    assign rd_addr[2] = bus.rd2_addr;

    // Search starts at the pointer; the last match below has highest priority.
    assign p0 = rr_q;
    assign p1 = inc3(p0);
    assign p2 = inc3(p1);

    always_comb begin
        pick = p0;
        if (rd_req[p2]) pick = p2;
        if (rd_req[p1]) pick = p1;
        if (rd_req[p0]) pick = p0;
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_dl_d = gnt_dl_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        valid_d  = '0;
        rdq_d    = rdq_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dl_req) begin
                    gnt_dl_d = 1'b1;
                    addr_d   = bus.dl_addr;
                    data_d   = bus.dl_data;
                    we_d     = 1'b1;
                    state_d  = REQ;
                end else if (|rd_req) begin
                    gnt_dl_d = 1'b0;
                    gnt_d    = pick;
                    addr_d   = rd_addr[pick];
                    data_d   = '0;
                    we_d     = 1'b0;
                    rr_d     = inc3(pick);
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.sdram_ack) state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.sdram_valid) begin
                    rdq_d[gnt_q]   = bus.sdram_q;
                    valid_d[gnt_q] = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_q     <= 2'd0;
            gnt_dl_q <= 1'b0;
            gnt_q    <= 2'd0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            valid_q  <= '0;
            for (int i = 0; i < 3; i++) rdq_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_dl_q <= gnt_dl_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            valid_q  <= valid_d;
            for (int i = 0; i < 3; i++) rdq_q[i] <= rdq_d[i];
        end
    end

    assign ack_en         = bus.sdram_ack && (state_q == REQ);
    assign bus.dl_ack     = ack_en && gnt_dl_q;
    assign bus.rd0_ack    = ack_en && !gnt_dl_q && (gnt_q == 2'd0);
    assign bus.rd1_ack    = ack_en && !gnt_dl_q && (gnt_q == 2'd1);
    assign bus.rd2_ack    = ack_en && !gnt_dl_q && (gnt_q == 2'd2);

    assign bus.rd0_valid  = valid_q[0];
    assign bus.rd1_valid  = valid_q[1];
    assign bus.rd2_valid  = valid_q[2];
    assign bus.rd0_q      = rdq_q[0];
    assign bus.rd1_q      = rdq_q[1];
    assign bus.rd2_q      = rdq_q[2];

    assign bus.sdram_req  = (state_q == REQ);
    assign bus.sdram_addr = addr_q;
    assign bus.sdram_data = data_q;
    assign bus.sdram_we   = we_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: the bench plays both the clients and
// the SDRAM controller, with hand-computed expectations.
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    localparam logic [AW-1:0] A0 = 23'h000100;
    localparam logic [AW-1:0] A1 = 23'h000123;
    localparam logic [AW-1:0] A2 = 23'h000200;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] acks();
        return {bus.rd2_ack, bus.rd1_ack, bus.rd0_ack};
    endfunction

    function automatic logic [2:0] valids();
        return {bus.rd2_valid, bus.rd1_valid, bus.rd0_valid};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int p);
        case (p)
            0:       return A0;
            1:       return A1;
            default: return A2;
        endcase
    endfunction

    function automatic logic [DW-1:0] q_of(input int p);
        case (p)
            0:       return bus.rd0_q;
            1:       return bus.rd1_q;
            default: return bus.rd2_q;
        endcase
    endfunction

    task automatic set_req(input int p, input logic v);
        case (p)
            0:       bus.rd0_req = v;
            1:       bus.rd1_req = v;
            default: bus.rd2_req = v;
        endcase
    endtask

    task automatic wait_sreq();
        int k = 0;
        while (!bus.sdram_req && k < 20) begin
            tick(1);
            k++;
        end
        chk("sdram_req_seen", bus.sdram_req, 1);
    endtask

    task automatic serve_rd(input int p, input logic [DW-1:0] d,
                            input int ack_dly, input int val_dly,
                            input bit rereq);
        wait_sreq();
        chk("rd_addr", bus.sdram_addr, addr_of(p));
        chk("rd_we", bus.sdram_we, 0);
        chk("rd_data_zero", bus.sdram_data, 0);
        tick(ack_dly);
        chk("req_hold", bus.sdram_req, 1);
        chk("addr_hold", bus.sdram_addr, addr_of(p));
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        chk("rd_ack_vec", acks(), 64'(3'b001 << p));
        chk("dl_ack_quiet", bus.dl_ack, 0);
        tick(1);
        bus.sdram_ack = 1'b0;
        set_req(p, 1'b0);
        chk("req_drop", bus.sdram_req, 0);
        chk("ack_gone", acks(), 0);
        tick(val_dly);
        bus.sdram_valid = 1'b1;
        bus.sdram_q = d;
        tick(1);
        bus.sdram_valid = 1'b0;
        chk("valid_vec", valids(), 64'(3'b001 << p));
        chk("rd_q", q_of(p), d);
        tick(1);
        chk("valid_end", valids(), 0);
        if (rereq) set_req(p, 1'b1);
    endtask

    task automatic serve_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_sreq();
        chk("wr_we", bus.sdram_we, 1);
        chk("wr_addr", bus.sdram_addr, a);
        chk("wr_data", bus.sdram_data, d);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        chk("dl_ack", bus.dl_ack, 1);
        chk("wr_rd_acks", acks(), 0);
        tick(1);
        bus.sdram_ack = 1'b0;
        bus.dl_req = 1'b0;
        chk("wr_req_drop", bus.sdram_req, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dl_addr = '0; bus.dl_data = '0; bus.dl_req = 1'b0;
        bus.rd0_addr = A0; bus.rd1_addr = A1; bus.rd2_addr = A2;
        bus.rd0_req = 1'b0; bus.rd1_req = 1'b0; bus.rd2_req = 1'b0;
        bus.sdram_ack = 1'b0; bus.sdram_valid = 1'b0; bus.sdram_q = '0;
        #1;
        chk("rst_req", bus.sdram_req, 0);
        chk("rst_we", bus.sdram_we, 0);
        chk("rst_addr", bus.sdram_addr, 0);
        chk("rst_data", bus.sdram_data, 0);
        chk("rst_valids", valids(), 0);
        chk("rst_q0", bus.rd0_q, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // single read with ack after 2 cycles, valid 4 cycles later
        bus.rd1_req = 1'b1;
        chk("lat_pre", bus.sdram_req, 0);
        tick(1);
        chk("lat_post", bus.sdram_req, 1);
        serve_rd(1, 32'hDEADBEEF, 2, 4, 1'b0);
        chk("single_we", bus.sdram_we, 0);

        // round robin with all ports held
        do_reset();
        bus.rd0_req = 1'b1; bus.rd1_req = 1'b1; bus.rd2_req = 1'b1;
        serve_rd(0, 32'hA0A0A0A0, 1, 1, 1'b1);
        serve_rd(1, 32'hA1A1A1A1, 1, 1, 1'b1);
        chk("q0_hold", bus.rd0_q, 32'hA0A0A0A0);
        serve_rd(2, 32'hA2A2A2A2, 1, 1, 1'b1);
        serve_rd(0, 32'hB0B0B0B0, 1, 1, 1'b0);
        serve_rd(1, 32'hB1B1B1B1, 1, 1, 1'b0);
        serve_rd(2, 32'hB2B2B2B2, 1, 1, 1'b0);

        // download priority over pending reads
        do_reset();
        bus.dl_addr = 23'h000010;
        bus.dl_data = 32'h11223344;
        bus.dl_req = 1'b1; bus.rd0_req = 1'b1; bus.rd2_req = 1'b1;
        serve_wr(23'h000010, 32'h11223344);
        serve_rd(0, 32'hC0C0C0C0, 1, 1, 1'b0);
        serve_rd(2, 32'hC2C2C2C2, 1, 1, 1'b0);

        // spurious valid in IDLE, then in REQ
        bus.sdram_valid = 1'b1; bus.sdram_q = 32'h0BAD0BAD;
        tick(1);
        bus.sdram_valid = 1'b0;
        chk("spur_idle_valid", valids(), 0);
        chk("spur_idle_q", bus.rd0_q, 32'hC0C0C0C0);
        bus.rd0_req = 1'b1;
        tick(1);
        bus.sdram_valid = 1'b1;
        tick(1);
        bus.sdram_valid = 1'b0;
        chk("spur_req_valid", valids(), 0);
        chk("spur_req_q", bus.rd0_q, 32'hC0C0C0C0);
        chk("spur_req_held", bus.sdram_req, 1);
        serve_rd(0, 32'hC1C1C1C1, 1, 2, 1'b0);

        // reset while a read is in WAIT
        bus.rd1_req = 1'b1;
        wait_sreq();
        chk("mid_addr", bus.sdram_addr, A1);
        bus.sdram_ack = 1'b1;
        tick(1);
        bus.sdram_ack = 1'b0;
        bus.rd1_req = 1'b0;
        chk("mid_in_wait", bus.sdram_req, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", bus.sdram_addr, 0);
        chk("mid_rst_q0", bus.rd0_q, 0);
        chk("mid_rst_acks", acks(), 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        bus.sdram_valid = 1'b1; bus.sdram_q = 32'hFFFF0000;
        tick(1);
        bus.sdram_valid = 1'b0;
        chk("mid_no_valid", valids(), 0);
        chk("mid_q1", bus.rd1_q, 0);
        chk("mid_idle", bus.sdram_req, 0);
        bus.rd1_req = 1'b1; bus.rd2_req = 1'b1;
        serve_rd(1, 32'hD1D1D1D1, 1, 1, 1'b0);
        serve_rd(2, 32'hD2D2D2D2, 1, 1, 1'b0);

        // requester drops its request right after the grant
        bus.rd2_req = 1'b1;
        tick(1);
        chk("drop_granted", bus.sdram_req, 1);
        bus.rd2_req = 1'b0;
        serve_rd(2, 32'hE2E2E2E2, 2, 2, 1'b0);
        bus.rd0_req = 1'b1;
        serve_rd(0, 32'hE0E0E0E0, 1, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, SDRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SDRAM word data width.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 dl_addr  input  ADDR_WIDTH  download write address.
REQ-006 dl_data  input  DATA_WIDTH  download write data.
REQ-007 dl_req  input  1  download write request, held until dl_ack.
REQ-008 dl_ack  output  1  download request accepted.
REQ-009 rdN_addr  input  ADDR_WIDTH  read address, one port for each N = 0, 1, 2.
REQ-010 rdN_req  input  1  read request, N = 0..2, held until rdN_ack.
REQ-011 rdN_ack  output  1  read request accepted, N = 0..2.
REQ-012 rdN_valid  output  1  one-cycle pulse: rdN_q is updated, N = 0..2.
REQ-013 rdN_q  output  DATA_WIDTH  read data, N = 0..2.
REQ-014 sdram_addr  output  ADDR_WIDTH  controller address.
REQ-015 sdram_data  output  DATA_WIDTH  controller write data.
REQ-016 sdram_we  output  1  write enable, 1 = write.
REQ-017 sdram_req  output  1  controller request.
REQ-018 sdram_ack  input  1  controller accepted the request.
REQ-019 sdram_valid  input  1  controller read data valid.
REQ-020 sdram_q  input  DATA_WIDTH  controller read data.

Function
REQ-021 The block SHALL have 3 states: IDLE, REQ (sdram_req high, waiting for sdram_ack) and WAIT (read in flight, waiting for sdram_valid).
REQ-022 At most one transaction SHALL be outstanding at the controller.
REQ-023 In IDLE, when any request is high, the block SHALL register grant, addr, data and we, then enter REQ on the next edge.
- Latency: request sampled at edge N -> sdram_req high from edge N+1.
REQ-024 Priority SHALL be: dl_req above all read ports; read ports by round-robin.
REQ-025 Round-robin: after read port i is granted, search order SHALL start at (i+1) mod 3.
- The pointer SHALL reset to port 0.
- Download grants SHALL NOT change the pointer.
REQ-026 sdram_req, sdram_addr, sdram_data and sdram_we SHALL stay stable throughout REQ.
REQ-027 The granted port's ack SHALL be combinational: sdram_ack AND state==REQ AND granted port; other acks SHALL be 0.
REQ-028 On sdram_ack in REQ:
- sdram_req SHALL drop on the next edge.
- A write grant SHALL go to IDLE.
- A read grant SHALL go to WAIT.
REQ-029 On sdram_valid in WAIT:
- sdram_q SHALL be registered into the owner's rdN_q.
- rdN_valid SHALL pulse for exactly one cycle, at edge+1.
- The state SHALL go to IDLE.
REQ-030 rdN_q SHALL hold its value until that port's next valid.
REQ-031 sdram_valid outside WAIT SHALL be ignored; no output changes.
REQ-032 sdram_data SHALL be 0 for read grants.
REQ-033 A request dropped before its ack does not cancel an issued transaction; a granted read SHALL still complete and pulse valid.
REQ-034 Re-arbitration SHALL occur in IDLE only; the earliest new sdram_req is 1 cycle after return to IDLE.

Reset
REQ-035 reset_n low SHALL immediately force:
- state IDLE and round-robin pointer 0;
- sdram_req, sdram_we, all acks and all valids to 0;
- sdram_addr, sdram_data and all rdN_q to 0.
REQ-036 Reset asserted during REQ or WAIT SHALL abandon the transaction; no valid pulse after reset release.
REQ-037 Reset release SHALL NOT be self-timed; the first grant occurs on the first edge in IDLE with a request high.

Verification
REQ-038 Single read: rd1_req, rd1_addr=0x000123; controller acks after 2 cycles, valid with q=0xDEADBEEF 4 cycles later -> rd1_ack one cycle, rd1_valid one cycle, rd1_q=0xDEADBEEF, sdram_we=0.
REQ-039 Round-robin: rd0, rd1, rd2 all held high, each re-requested after valid -> grant order 0,1,2,0,1,2; no port granted twice consecutively.
REQ-040 Download priority: dl_req high with rd0/rd2 pending; dl_addr=0x000010, dl_data=0x11223344 -> first sdram_req has we=1 and those values; reads follow as rd0 then rd2.
REQ-041 Spurious valid: sdram_valid pulsed in IDLE and in REQ -> no rdN_valid; rdN_q unchanged.
REQ-042 Reset mid-read: reset_n low in WAIT, sdram_valid arrives after release -> no rdN_valid; state IDLE; pointer 0.
REQ-043 Dropped request: rd2_req falls the cycle after its grant -> read still completes with rd2_valid pulse; then arbitration resumes.
